// File: rtl/pwm_level_decoder.sv
// Decodes a dimmer PWM stream into a 0..15 brightness level by measuring high
// time per frame and dividing it by the per-level step with round-half-up.
module pwm_level_decoder #(
    parameter int PERIOD  = 250000,
    parameter int STEP    = 15625,
    parameter int TOL     = 2500,
    parameter int TIMEOUT = 500000
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [3:0] level,
    output logic       level_valid,
    output logic       period_err,
    output logic       locked
);

    localparam logic [18:0] TIMEOUT_C = 19'(TIMEOUT);
    localparam logic [19:0] LEN_MIN   = 20'(PERIOD - TOL);
    localparam logic [19:0] LEN_MAX   = 20'(PERIOD + TOL);
    localparam logic [18:0] STEP_C    = 19'(STEP);
    localparam logic [18:0] HALF_C    = 19'(STEP / 2);
    localparam logic [17:0] HIGH_MAX  = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} state_t;

    state_t      state_reg, state_next;
    logic        sync_reg, pwm_s_reg, pwm_d_reg;
    logic [18:0] period_cnt_reg, period_cnt_next;
    logic [17:0] high_cnt_reg, high_cnt_next;
    logic [18:0] rem_reg, rem_next;
    logic [3:0]  q_reg, q_next;
    logic [3:0]  iter_reg, iter_next;
    logic [3:0]  level_reg, level_next;
    logic        level_valid_reg, level_valid_next;
    logic        period_err_reg, period_err_next;
    logic        locked_reg, locked_next;

    logic        rise;
    logic [19:0] frame_len;
    logic        in_tol;
    logic        timeout;

    assign rise      = pwm_s_reg & ~pwm_d_reg;
    // Counter was zeroed on the opening rise clock, so +1 accounts for that clock.
    assign frame_len = {1'b0, period_cnt_reg} + 20'd1;
    assign in_tol    = (frame_len >= LEN_MIN) && (frame_len <= LEN_MAX);
    assign timeout   = (period_cnt_reg == TIMEOUT_C);

    always_ff @(posedge clock_50) begin
        if (reset) begin
            sync_reg        <= 1'b0;
            pwm_s_reg       <= 1'b0;
            pwm_d_reg       <= 1'b0;
            state_reg       <= IDLE;
            period_cnt_reg  <= '0;
            high_cnt_reg    <= '0;
            rem_reg         <= '0;
            q_reg           <= '0;
            iter_reg        <= '0;
            level_reg       <= '0;
            level_valid_reg <= 1'b0;
            period_err_reg  <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            sync_reg        <= pwm_in;
            pwm_s_reg       <= sync_reg;
            pwm_d_reg       <= pwm_s_reg;
            state_reg       <= state_next;
            period_cnt_reg  <= period_cnt_next;
            high_cnt_reg    <= high_cnt_next;
            rem_reg         <= rem_next;
            q_reg           <= q_next;
            iter_reg        <= iter_next;
            level_reg       <= level_next;
            level_valid_reg <= level_valid_next;
            period_err_reg  <= period_err_next;
            locked_reg      <= locked_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        rem_next         = rem_reg;
        q_next           = q_reg;
        iter_next        = iter_reg;
        level_next       = level_reg;
        level_valid_next = 1'b0;
        period_err_next  = period_err_reg;
        locked_next      = locked_reg;

        // The rise clock itself is high, so the new frame's high count starts at 1.
        if (rise) begin
            period_cnt_next = '0;
            high_cnt_next   = 18'd1;
        end else begin
            period_cnt_next = (period_cnt_reg >= TIMEOUT_C) ? TIMEOUT_C : period_cnt_reg + 19'd1;
            high_cnt_next   = (pwm_s_reg && high_cnt_reg != HIGH_MAX) ? high_cnt_reg + 18'd1
                                                                      : high_cnt_reg;
        end

        if (state_reg != IDLE && !rise && timeout) begin
            state_next = IDLE;
            if (pwm_s_reg) begin
                period_err_next = 1'b1;
                locked_next     = 1'b0;
            end else begin
                level_next       = 4'd0;
                level_valid_next = 1'b1;
                period_err_next  = 1'b0;
                locked_next      = 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) state_next = MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        if (in_tol) begin
                            rem_next   = {1'b0, high_cnt_reg} + HALF_C;
                            q_next     = 4'd0;
                            iter_next  = 4'd0;
                            state_next = DIVIDE;
                        end else begin
                            period_err_next = 1'b1;
                            locked_next     = 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    if (rise) begin
                        period_err_next = 1'b1;
                        locked_next     = 1'b0;
                        state_next      = MEASURE;
                    end else begin
                        if (rem_reg >= STEP_C && q_reg != 4'd15) begin
                            rem_next = rem_reg - STEP_C;
                            q_next   = q_reg + 4'd1;
                        end
                        iter_next = iter_reg + 4'd1;
                        if (iter_reg == 4'd15) state_next = DONE;
                    end
                end
                DONE: begin
                    if (rise) begin
                        period_err_next = 1'b1;
                        locked_next     = 1'b0;
                    end else begin
                        level_next       = q_reg;
                        level_valid_next = 1'b1;
                        period_err_next  = 1'b0;
                        locked_next      = 1'b1;
                    end
                    state_next = MEASURE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign level       = level_reg;
    assign level_valid = level_valid_reg;
    assign period_err  = period_err_reg;
    assign locked      = locked_reg;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Randomized and directed bench for pwm_level_decoder with scaled-down timing
// and a frame-level reference model built from the sampled pwm_in history.
module tb_pwm_level_decoder;

    localparam int P  = 800;
    localparam int S  = 50;
    localparam int T  = 8;
    localparam int TO = 1600;
    localparam int HMAX = 65535;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_in = 1'b0;
    logic [3:0] level;
    logic       level_valid, period_err, locked;

    always #5 clk = ~clk;

    pwm_level_decoder #(.PERIOD(P), .STEP(S), .TOL(T), .TIMEOUT(TO)) dut (
        .clock_50(clk), .reset(reset), .pwm_in(pwm_in),
        .level(level), .level_valid(level_valid),
        .period_err(period_err), .locked(locked)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hist [0:HMAX];

    // Reference model state.
    int last_rst = 0, last_c = 0, last_d = 0, due = 0, plvl = 0, in_rise_edge = 0;
    bit armed = 0, pend = 0;
    logic [3:0] m_level = 0;
    bit m_valid = 0, m_err = 0, m_locked = 0;

    int pulse_lvls[$];
    int pulse_edge = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a rise in the sampled stream takes effect two clocks later; results
    // of a good frame appear 17 clocks after that unless another rise intervenes.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc > HMAX) begin
                $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
                $fatal(1, "cycle budget exceeded");
            end
            hist[cyc] = reset ? 1'b0 : pwm_in;
            if (hist[cyc] && !hist[cyc-1]) in_rise_edge = cyc;
            m_valid = 0;
            if (reset) begin
                last_rst = cyc; armed = 0; pend = 0;
                m_level = 0; m_err = 0; m_locked = 0;
            end else if ((cyc - 2 > last_rst) && hist[cyc-2] && !hist[cyc-3]) begin
                int c;
                c = cyc - 2;
                if (!armed) begin
                    armed = 1;
                end else if (pend) begin
                    pend = 0; m_err = 1; m_locked = 0;
                end else begin
                    int len, hs;
                    len = c - last_c;
                    hs = 0;
                    for (int i = last_c; i < c; i++) hs += int'(hist[i]);
                    if (len >= P - T && len <= P + T) begin
                        plvl = (2 * hs + S) / (2 * S);
                        if (plvl > 15) plvl = 15;
                        pend = 1;
                        due = cyc + 17;
                    end else begin
                        m_err = 1; m_locked = 0;
                    end
                end
                last_c = c;
                last_d = cyc;
            end else if (pend && cyc == due) begin
                pend = 0; m_level = 4'(plvl); m_valid = 1; m_err = 0; m_locked = 1;
            end else if (armed && cyc == last_d + TO + 1) begin
                armed = 0;
                if (hist[cyc-2]) begin
                    m_err = 1; m_locked = 0;
                end else begin
                    m_level = 0; m_valid = 1; m_err = 0; m_locked = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("outputs", int'({level, level_valid, period_err, locked}),
                    int'({m_level, m_valid, m_err, m_locked}));
                if (level_valid) begin
                    pulse_lvls.push_back(int'(level));
                    pulse_edge = cyc;
                end
            end
        end
    end

    task automatic drive(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int len, input int hi);
        drive(1'b1, hi);
        drive(1'b0, len - hi);
    endtask

    initial begin
        int p0;
        int s2_exp [4] = '{7, 7, 8, 15};
        int s3_len [8] = '{800, 832, 800, 808, 809, 792, 791, 800};
        int s3_err [8] = '{0, 0, 1, 0, 0, 1, 0, 1};
        int s3_lvl [8] = '{7, 5, 5, 5, 5, 5, 5, 5};

        // Reset state
        repeat (5) @(negedge clk);
        chk("reset_outputs", int'({level, level_valid, period_err, locked}), 0);
        reset = 1'b0;
        drive(1'b0, 10);

        // Steady level 7 frames and latency
        p0 = pulse_lvls.size();
        repeat (5) frame(P, 350);
        chk("s1_pulses", pulse_lvls.size() - p0, 4);
        chk("s1_level", int'(level), 7);
        chk("s1_model_level", int'(m_level), 7);
        chk("s1_err_locked", int'({period_err, locked}), 1);
        chk("s1_latency_clocks", pulse_edge - in_rise_edge + 1, 20);

        // Rounding boundaries and saturation
        p0 = pulse_lvls.size();
        frame(P, 374); frame(P, 375); frame(P, 795); frame(P, 350);
        chk("s2_pulses", pulse_lvls.size() - p0, 4);
        if (pulse_lvls.size() >= p0 + 4)
            for (int i = 0; i < 4; i++) chk("s2_level_seq", pulse_lvls[p0+i], s2_exp[i]);

        // Out-of-tolerance frames and tolerance edges
        for (int k = 0; k < 8; k++) begin
            p0 = pulse_lvls.size();
            drive(1'b1, 250);
            chk("s3_err", int'(period_err), s3_err[k]);
            chk("s3_locked", int'(locked), 1 - s3_err[k]);
            chk("s3_level", int'(level), s3_lvl[k]);
            chk("s3_pulse", pulse_lvls.size() - p0, 1 - s3_err[k]);
            drive(1'b0, s3_len[k] - 250);
        end

        // Stuck low after level 9
        frame(P, 450); frame(P, 450);
        p0 = pulse_lvls.size();
        drive(1'b1, 450);
        drive(1'b0, TO + 50);
        chk("s4_pulses", pulse_lvls.size() - p0, 2);
        chk("s4_level", int'(level), 0);
        chk("s4_err_locked", int'({period_err, locked}), 1);
        chk("s4_timeout_delay", pulse_edge - in_rise_edge, TO + 3);

        // Stuck high after level 6, then recovery at level 4
        frame(P, 300); frame(P, 300);
        p0 = pulse_lvls.size();
        drive(1'b1, TO + 50);
        chk("s5_pulses", pulse_lvls.size() - p0, 1);
        chk("s5_err_locked", int'({period_err, locked}), 2);
        chk("s5_level", int'(level), 6);
        drive(1'b0, 100);
        repeat (3) frame(P, 200);
        drive(1'b1, 50);
        chk("s5_recover_level", int'(level), 4);
        chk("s5_recover_locked", int'(locked), 1);
        drive(1'b0, P - 50);

        // Reset pulsed while a divide is in flight
        frame(P, 150);
        p0 = pulse_lvls.size();
        drive(1'b1, 7);
        reset = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("s6_outputs_after_reset", int'({level, level_valid, period_err, locked}), 0);
        drive(1'b0, 20);
        drive(1'b1, 150);
        drive(1'b0, 650);
        chk("s6_no_pulse", pulse_lvls.size() - p0, 0);
        drive(1'b1, 30);
        chk("s6_pulse", pulse_lvls.size() - p0, 1);
        chk("s6_level", int'(level), 3);
        drive(1'b0, P - 30);

        // Randomized frames, including off-tolerance and aborting short frames
        for (int k = 0; k < 16; k++) begin
            int sel, len;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = P + T + 1 + int'($urandom_range(0, 40));
            else if (sel == 1) len = int'($urandom_range(5, 16));
            else if (sel == 2) len = P - T - 1 - int'($urandom_range(0, 40));
            else               len = P - T + int'($urandom_range(0, 2 * T));
            frame(len, int'($urandom_range(1, len - 1)));
        end
        drive(1'b1, 30);
        drive(1'b0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
